// File: rtl/fpnew_divsqrt_wb_ctrl.sv
// fpnew_divsqrt_wb_ctrl: issue/writeback sequencer for the iterative FP32
// div/sqrt datapath. One operation in flight at a time; the result is held
// on a valid/ready port until accepted, with back-to-back issue allowed on
// the accepting cycle.
// Optional feature macro: FPNEW_DIVSQRT_EARLY_EXIT_EN (special operands
// bypass the datapath and complete one cycle after accept).
module fpnew_divsqrt_wb_ctrl #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned TAG_WIDTH   = 5,
    parameter int unsigned DIV_CYCLES  = 11,
    parameter int unsigned SQRT_CYCLES = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 op_is_sqrt_i,
    input  logic                 in_special_i,
    input  logic [WIDTH-1:0]     special_result_i,
    input  logic [4:0]           special_status_i,
    input  logic [TAG_WIDTH-1:0] tag_i,
    output logic                 dp_start_o,
    input  logic [WIDTH-1:0]     dp_result_i,
    input  logic [4:0]           dp_status_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [WIDTH-1:0]     out_result_o,
    output logic [4:0]           out_status_o,
    output logic [TAG_WIDTH-1:0] out_tag_o,
    output logic                 busy_o
);

    localparam int unsigned MAX_CYCLES = (DIV_CYCLES > SQRT_CYCLES) ? DIV_CYCLES : SQRT_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] SQRT_LOAD = CNT_W'(SQRT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        HOLD
    } state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_out_valid;
    logic [WIDTH-1:0]       r_out_result;
    logic [4:0]             r_out_status;
    logic [TAG_WIDTH-1:0]   r_out_tag;

    logic                   w_in_ready;
    logic                   w_accept;
    logic                   w_early;

    // Issue readiness: idle always, hold only when the held result drains this cycle.
    always_comb begin
        w_in_ready = 1'b0;
        unique case (r_state)
            IDLE:    w_in_ready = 1'b1;
            HOLD:    w_in_ready = out_ready_i;
            default: w_in_ready = 1'b0;
        endcase
        if (flush_i) begin
            w_in_ready = 1'b0;
        end
    end

    assign w_accept = in_valid_i & w_in_ready;

`ifdef FPNEW_DIVSQRT_EARLY_EXIT_EN
    assign w_early    = w_accept & in_special_i;
    assign dp_start_o = w_accept & ~in_special_i;
`else
    logic w_unused_special;
    assign w_unused_special = ^{in_special_i, special_result_i, special_status_i};
    assign w_early    = 1'b0;
    assign dp_start_o = w_accept;
`endif

    // Sequencer FSM: accept, count latency, capture, hold until handshake.
    // Accept is shared by IDLE and HOLD since in_ready already encodes the drain condition.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_status <= '0;
            r_out_tag    <= '0;
        end else if (flush_i) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE, HOLD: begin
                    if (r_state == HOLD && out_ready_i) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                    if (w_accept) begin
                        r_out_tag <= tag_i;
                        if (w_early) begin
                            r_state      <= HOLD;
                            r_cnt        <= '0;
                            r_out_valid  <= 1'b1;
                            r_out_result <= special_result_i;
                            r_out_status <= special_status_i;
                        end else begin
                            r_state     <= BUSY;
                            r_cnt       <= op_is_sqrt_i ? SQRT_LOAD : DIV_LOAD;
                            r_out_valid <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state      <= HOLD;
                        r_out_valid  <= 1'b1;
                        r_out_result <= dp_result_i;
                        r_out_status <= dp_status_i;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign in_ready_o   = w_in_ready;
    assign out_valid_o  = r_out_valid;
    assign out_result_o = r_out_result;
    assign out_status_o = r_out_status;
    assign out_tag_o    = r_out_tag;
    assign busy_o       = (r_state != IDLE);

endmodule

// File: doc/fpnew_divsqrt_wb_ctrl.md
Name: fpnew_divsqrt_wb_ctrl

Overview:
Issue/writeback sequencer for the iterative FP32 div/sqrt datapath inside the CV32E40P FPU wrapper.
- Accepts one operation at a time from the issue side and starts the datapath.
- Counts the fixed iteration latency, captures the result, and holds it on a valid/ready writeback port until the core accepts it.
- Guarantees that no new operation starts while a held result is still unaccepted, except in the cycle where that result is accepted.

Parameters:
WIDTH, 32, result data width
TAG_WIDTH, 5, destination-register tag width
DIV_CYCLES, 11, cycles from accept to out_valid_o for division (must be >= 2)
SQRT_CYCLES, 10, cycles from accept to out_valid_o for square root (must be >= 2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active-low
flush_i  in  1  synchronous kill of in-flight or held operation
in_valid_i  in  1  issue request
in_ready_o  out  1  issue accept; an op is accepted when in_valid_i & in_ready_o
op_is_sqrt_i  in  1  1 = sqrt, 0 = div
in_special_i  in  1  operands are special (NaN/Inf/zero); only used with the optional feature
special_result_i  in  WIDTH  precomputed special-case result
special_status_i  in  5  precomputed special-case flags
tag_i  in  TAG_WIDTH  destination tag
dp_start_o  out  1  one-cycle datapath start pulse
dp_result_i  in  WIDTH  datapath result, valid on the capture cycle
dp_status_i  in  5  datapath flags {NV,DZ,OF,UF,NX}
out_valid_o  out  1  writeback valid
out_ready_i  in  1  writeback accept
out_result_o  out  WIDTH  held result
out_status_o  out  5  held flags
out_tag_o  out  TAG_WIDTH  held tag
busy_o  out  1  state != IDLE

Behaviour:
- Reset (async, rst_ni low): state IDLE, counter 0, out_valid_o 0, out_result_o 0, out_status_o 0, out_tag_o 0, busy_o 0. Outputs take these values immediately on reset assertion, including mid-operation.
- States: IDLE, BUSY, HOLD.
- in_ready_o is combinational:
  - 1 in IDLE;
  - equal to out_ready_i in HOLD;
  - 0 in BUSY;
  - forced to 0 whenever flush_i = 1.
- dp_start_o = in_valid_i & in_ready_o. Combinational, so it pulses in the accept cycle.
- Accept at cycle T:
  - latch tag_i;
  - load counter with N-1, where N = SQRT_CYCLES if op_is_sqrt_i, else DIV_CYCLES;
  - next state BUSY.
- BUSY:
  - counter decrements every cycle;
  - when counter == 1, capture dp_result_i/dp_status_i into the output registers and go to HOLD.
  - Result: out_valid_o rises at exactly T+N.
- HOLD: out_valid_o = 1. Result, status and tag stay stable until the handshake.
  - out_ready_i = 1 with no new accept: go to IDLE; out_valid_o 0 next cycle.
  - out_ready_i = 1 with a same-cycle accept (back-to-back): go directly to BUSY with the new tag/counter; out_valid_o 0 next cycle.
- Invariant: an accept in HOLD never happens without out_ready_i = 1 in the same cycle.
- flush_i (highest priority, any state):
  - next state IDLE, counter 0, out_valid_o 0;
  - a pending handshake in that cycle is discarded;
  - no accept occurs in that cycle.
- Counter width: clog2(max(DIV_CYCLES, SQRT_CYCLES)+1). The counter never wraps and never decrements below 1 in BUSY.

Optional Feature:
FPNEW_DIVSQRT_EARLY_EXIT_EN
- Defined: an accept with in_special_i = 1 does not pulse dp_start_o. It captures special_result_i/special_status_i and tag_i and goes straight to HOLD, so out_valid_o rises at T+1.
- Undefined: in_special_i, special_result_i and special_status_i are ignored, and all ops take the full N-cycle latency through the datapath.

Test Plan:
- Div, out_ready_i held 1: accept at cycle 5, tag 3, dp_result_i = 0x3F800000 at cycle 15 -> dp_start_o pulses at cycle 5; out_valid_o = 1 only at cycle 16 with result 0x3F800000, tag 3; busy_o 0 at cycle 17.
- Sqrt: accept at cycle 0 -> out_valid_o rises at cycle 10, i.e. 10 cycles after accept; in_ready_o = 0 for cycles 1..9.
- Writeback stall: out_ready_i = 0 for 4 cycles after out_valid_o, with in_valid_i = 1 throughout -> in_ready_o stays 0 and result/tag remain stable. On the first cycle out_ready_i = 1, a second op is accepted in the same cycle (dp_start_o = 1) and out_valid_o drops next cycle.
- Flush: flush_i at cycle 4 of a div -> IDLE next cycle, out_valid_o never rises, in_ready_o 1 at cycle 5. Flush in HOLD with out_ready_i = 1 -> no writeback counted.
- Async reset: rst_ni low mid-BUSY -> out_valid_o/busy_o 0 immediately. After release, a new op completes with normal latency.
- With FPNEW_DIVSQRT_EARLY_EXIT_EN, in_special_i = 1, special_result_i = 0x7FC00000, special_status_i = 5'b10000 -> out_valid_o at T+1 with those values and no dp_start_o. Without the macro -> latency N, result from dp_result_i.
